mem_write_buffer: RTL and testbench

- Store write buffer and load arbiter between the EX/MEM pipeline latch and the single-port data memory.
- Stores are posted into a small FIFO and retire to memory in idle memory cycles. Loads get priority and are checked against pending stores for ordering.
- Loads stall the pipeline until their data returns.

---
 rtl/mem_write_buffer_if.sv | 33 +++
 rtl/mem_write_buffer.sv | 140 ++++++++++++++
 tb/tb_mem_write_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_buffer_if.sv
// Signal bundle shared by the EX/MEM latch, the store write buffer and the data memory.
interface mem_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_done;
    logic          stall;
    logic          empty;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_memwrite;
    logic          mem_memread;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_data, ld_done, stall, empty,
               mem_addr, mem_wdata, mem_memwrite, mem_memread
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_data, ld_done, stall, empty,
               mem_addr, mem_wdata, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-store FIFO with load priority in front of a single-port data memory.
// Define WBUF_FWD_EN to forward conflicting loads from the youngest matching store.
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_pop;
    logic [CW-1:0] count_nxt;
    logic [1:0]    op_q;
    logic          st_ready;
    logic          push;
    logic          pop;
    logic          ld_pend;
    logic          conflict;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          memwrite_q;
    logic          memread_q;
    logic [DW-1:0] ld_data_q;
    logic          ld_done_q;
`ifdef WBUF_FWD_EN
    logic [DW-1:0] fwd_data;
`endif

    assign st_ready         = (count != CW'(DEPTH));
    assign bus.st_ready     = st_ready;
    assign bus.empty        = (count == '0);
    assign bus.stall        = (bus.ld_valid & ~ld_done_q) | (bus.st_valid & ~st_ready);
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_memwrite = memwrite_q;
    assign bus.mem_memread  = memread_q;
    assign bus.ld_data      = ld_data_q;
    assign bus.ld_done      = ld_done_q;

    assign push      = bus.st_valid & st_ready;
    assign pop       = (op_q == OP_WRITE);
    assign ld_pend   = bus.ld_valid & ~ld_done_q & (op_q != OP_READ);
    assign rptr_nxt  = rptr + PW'(pop);
    assign count_pop = count - CW'(pop);
    assign count_nxt = count_pop + CW'(push);

    // When the buffer drains to nothing this edge, the incoming store is the new head.
    assign head_addr = (count_pop == '0) ? bus.st_addr : addr_q[rptr_nxt];
    assign head_data = (count_pop == '0) ? bus.st_data : data_q[rptr_nxt];

    // Scan oldest to youngest so the last hit is the youngest; a same-edge push is younger still.
    always_comb begin
        conflict = 1'b0;
`ifdef WBUF_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && !(pop && (k == 0)) &&
                (addr_q[rptr + PW'(k)] == bus.ld_addr)) begin
                conflict = 1'b1;
`ifdef WBUF_FWD_EN
                fwd_data = data_q[rptr + PW'(k)];
`endif
            end
        end
        if (push && (bus.st_addr == bus.ld_addr)) begin
            conflict = 1'b1;
`ifdef WBUF_FWD_EN
            fwd_data = bus.st_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wptr] <= bus.st_addr;
            data_q[wptr] <= bus.st_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            op_q        <= OP_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            memwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            ld_data_q   <= '0;
            ld_done_q   <= 1'b0;
        end else begin
            rptr  <= rptr_nxt;
            count <= count_nxt;
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            ld_done_q <= (op_q == OP_READ);
            if (op_q == OP_READ) begin
                ld_data_q <= bus.mem_rdata;
            end
            op_q       <= OP_IDLE;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            if (ld_pend && !conflict) begin
                op_q       <= OP_READ;
                memread_q  <= 1'b1;
                mem_addr_q <= bus.ld_addr;
            end else if (count_nxt != '0) begin
                op_q        <= OP_WRITE;
                memwrite_q  <= 1'b1;
                mem_addr_q  <= head_addr;
                mem_wdata_q <= head_data;
            end
`ifdef WBUF_FWD_EN
            if (ld_pend && conflict) begin
                ld_data_q <= fwd_data;
                ld_done_q <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer with a behavioural memory and a write log.
`timescale 1ns/1ps
module tb_mem_write_buffer;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    // Per-edge expectations for the fill sequence, bit 0 = first edge.
    localparam logic [8:0] FILL_RDY  = 9'b101111111;
    localparam logic [8:0] FILL_DONE = 9'b010010010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_write_buffer_if #(.AW(AW), .DW(DW)) bus ();

    mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] tbmem [logic [AW-1:0]];
    logic [AW-1:0] wlog_a [$];
    logic [DW-1:0] wlog_d [$];

    always @(posedge clk) begin
        if (bus.mem_memwrite) begin
            tbmem[bus.mem_addr] = bus.mem_wdata;
            wlog_a.push_back(bus.mem_addr);
            wlog_d.push_back(bus.mem_wdata);
        end
    end

    // Unwritten locations read back their own address.
    always @(negedge clk) begin
        if (bus.mem_memread)
            bus.mem_rdata = tbmem.exists(bus.mem_addr) ? tbmem[bus.mem_addr] : DW'(bus.mem_addr);
        else
            bus.mem_rdata = '0;
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    int   pushed = 0;
    logic acc;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        tick();
        tick();
        chk1("rst_st_ready", bus.st_ready, 1'b1);
        chk1("rst_empty", bus.empty, 1'b1);
        chk1("rst_stall", bus.stall, 1'b0);
        chk1("rst_ld_done", bus.ld_done, 1'b0);
        chk1("rst_memwrite", bus.mem_memwrite, 1'b0);
        chk1("rst_memread", bus.mem_memread, 1'b0);
        chkw("rst_mem_addr", bus.mem_addr, 32'h0);
        chkw("rst_ld_data", bus.ld_data, 32'h0);
        rst = 1'b0;
        tick();

        // Fill: stores every cycle while a load requester keeps the memory busy.
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'd10;
        bus.st_data  = 32'hA0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'd7;
        for (int e = 0; e < 9; e++) begin
            acc = bus.st_valid & bus.st_ready;
            tick();
            if (acc) pushed++;
            chk1($sformatf("fill_st_ready_e%0d", e + 1), bus.st_ready, FILL_RDY[e]);
            chk1($sformatf("fill_ld_done_e%0d", e + 1), bus.ld_done, FILL_DONE[e]);
            if (bus.ld_done) chkw($sformatf("fill_ld_data_e%0d", e + 1), bus.ld_data, 32'd7);
            if (!bus.st_ready) chk1("fill_stall_full", bus.stall, 1'b1);
            bus.st_addr  = AW'(10 + pushed);
            bus.st_data  = DW'(32'hA0 + pushed);
            bus.ld_valid = ~bus.ld_done;
        end
        chkw("fill_pushed", pushed, 32'd8);
        chk1("fill_memwrite", bus.mem_memwrite, 1'b1);
        chkw("fill_mem_addr", bus.mem_addr, 32'd15);
        chkw("fill_mem_wdata", bus.mem_wdata, 32'hA5);
        chk1("fill_empty", bus.empty, 1'b0);

        // Asynchronous reset in the middle of a write with three stores still queued.
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_empty", bus.empty, 1'b1);
        chk1("arst_st_ready", bus.st_ready, 1'b1);
        chk1("arst_memwrite", bus.mem_memwrite, 1'b0);
        chk1("arst_memread", bus.mem_memread, 1'b0);
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chkw("arst_wlog_size", wlog_a.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chkw($sformatf("order_addr_%0d", i), wlog_a[i], 32'd10 + i);
            chkw($sformatf("order_data_%0d", i), wlog_d[i], 32'hA0 + i);
        end
        chk1("arst_idle_empty", bus.empty, 1'b1);

        // Load priority over a buffered store.
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'd20;
        bus.st_data  = 32'd55;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'd7;
        #1;
        chk1("prio_stall_req", bus.stall, 1'b1);
        tick();
        bus.st_valid = 1'b0;
        chk1("prio_memread", bus.mem_memread, 1'b1);
        chkw("prio_rd_addr", bus.mem_addr, 32'd7);
        chk1("prio_no_write", bus.mem_memwrite, 1'b0);
        chk1("prio_not_empty", bus.empty, 1'b0);
        chk1("prio_done_early", bus.ld_done, 1'b0);
        tick();
        chk1("prio_ld_done", bus.ld_done, 1'b1);
        chkw("prio_ld_data", bus.ld_data, 32'd7);
        chk1("prio_memwrite", bus.mem_memwrite, 1'b1);
        chkw("prio_wr_addr", bus.mem_addr, 32'd20);
        chkw("prio_wr_data", bus.mem_wdata, 32'd55);
        chk1("prio_stall_done", bus.stall, 1'b0);
        bus.ld_valid = 1'b0;
        tick();
        chk1("prio_done_pulse", bus.ld_done, 1'b0);
        chk1("prio_drained", bus.empty, 1'b1);
        chkw("prio_wlog_addr", wlog_a[wlog_a.size() - 1], 32'd20);

        // Conflict: two stores to 30, the load arrives with the younger one.
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'd30;
        bus.st_data  = 32'h11;
        tick();
        chk1("conf_wr1", bus.mem_memwrite, 1'b1);
        chkw("conf_wr1_data", bus.mem_wdata, 32'h11);
        bus.st_data  = 32'h22;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'd30;
        #1;
        chk1("conf_stall_c0", bus.stall, 1'b1);
        tick();
        bus.st_valid = 1'b0;
        chk1("conf_wr2", bus.mem_memwrite, 1'b1);
        chkw("conf_wr2_data", bus.mem_wdata, 32'h22);
        chk1("conf_no_read_c1", bus.mem_memread, 1'b0);
`ifdef WBUF_FWD_EN
        chk1("fwd_ld_done", bus.ld_done, 1'b1);
        chkw("fwd_ld_data", bus.ld_data, 32'h22);
        chk1("fwd_stall_c1", bus.stall, 1'b0);
        bus.ld_valid = 1'b0;
        tick();
        chk1("fwd_done_pulse", bus.ld_done, 1'b0);
        chk1("fwd_no_read_c2", bus.mem_memread, 1'b0);
        chk1("fwd_empty", bus.empty, 1'b1);
`else
        chk1("conf_done_c1", bus.ld_done, 1'b0);
        chk1("conf_stall_c1", bus.stall, 1'b1);
        tick();
        chk1("conf_read", bus.mem_memread, 1'b1);
        chkw("conf_rd_addr", bus.mem_addr, 32'd30);
        chk1("conf_stall_c2", bus.stall, 1'b1);
        tick();
        chk1("conf_ld_done", bus.ld_done, 1'b1);
        chkw("conf_ld_data", bus.ld_data, 32'h22);
        chk1("conf_stall_c3", bus.stall, 1'b0);
        bus.ld_valid = 1'b0;
        tick();
`endif

        // Same-cycle store and load to 40; memory still holds its old value.
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'd40;
        bus.st_data  = 32'd5;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'd40;
        tick();
        bus.st_valid = 1'b0;
        chk1("same_wr", bus.mem_memwrite, 1'b1);
        chkw("same_wr_addr", bus.mem_addr, 32'd40);
        chk1("same_no_read", bus.mem_memread, 1'b0);
`ifdef WBUF_FWD_EN
        chk1("same_fwd_done", bus.ld_done, 1'b1);
        chkw("same_fwd_data", bus.ld_data, 32'd5);
        bus.ld_valid = 1'b0;
        tick();
`else
        chk1("same_done_c0", bus.ld_done, 1'b0);
        tick();
        chk1("same_read", bus.mem_memread, 1'b1);
        chkw("same_rd_addr", bus.mem_addr, 32'd40);
        tick();
        chk1("same_ld_done", bus.ld_done, 1'b1);
        chkw("same_ld_data", bus.ld_data, 32'd5);
        bus.ld_valid = 1'b0;
        tick();
`endif
        chk1("end_ld_done", bus.ld_done, 1'b0);
        chk1("end_empty", bus.empty, 1'b1);
        chk1("end_stall", bus.stall, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
